// File: rtl/oport_arb_if.sv
// Request/response bundle between the input-port requesters and one output-port arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface oport_arb_if #(
  parameter int PORTNUM = 16
);
  localparam int PW = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;

  logic [PORTNUM-1:0] i_req;
  logic               i_full;
  logic               i_done;
  logic [PORTNUM-1:0] o_resp;
  logic [PORTNUM-1:0] o_nresp;
  logic               o_port_ready;
  logic [PW-1:0]      o_owner;
  logic               o_owner_vld;
  logic               o_timeout;

  modport master (
    output i_req, i_full, i_done,
    input  o_resp, o_nresp, o_port_ready, o_owner, o_owner_vld, o_timeout
  );

  modport slave (
    input  i_req, i_full, i_done,
    output o_resp, o_nresp, o_port_ready, o_owner, o_owner_vld, o_timeout
  );
endinterface

// File: rtl/oport_arb.sv
// Round-robin output-port arbiter: grants one requester, holds the grant until
// done or timeout, then releases for one cycle and rotates priority past the owner.
module oport_arb #(
  parameter int PORTNUM = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  oport_arb_if.slave bus
);
  localparam int PW  = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PORTNUM-1:0] resp_q, resp_d;
  logic [PORTNUM-1:0] nresp_q, nresp_d;
  logic               vld_q, vld_d;
  logic               ready_q, ready_d;
  logic               tmo_q, tmo_d;
  logic [PW-1:0]      winner;

  // First set request bit at or after ptr, wrapping around the port range.
  function automatic logic [PW-1:0] rr_pick(input logic [PORTNUM-1:0] req,
                                            input logic [PW-1:0]      ptr);
    logic [PW-1:0] pick;
    logic [PW:0]   idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < PORTNUM; i++) begin
      idx = {1'b0, ptr} + PW1'(i);
      if (idx >= PW1'(PORTNUM)) idx = idx - PW1'(PORTNUM);
      if (!found && req[idx[PW-1:0]]) begin
        pick  = idx[PW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(bus.i_req, ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    resp_d  = '0;
    nresp_d = '0;
    vld_d   = vld_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_req != '0) begin
          if (bus.i_full) begin
            nresp_d = bus.i_req;
          end else begin
            resp_d[winner] = 1'b1;
            owner_d        = winner;
            vld_d          = 1'b1;
            cnt_d          = '0;
            state_d        = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // done takes precedence over a timeout landing in the same cycle
        if (bus.i_done) begin
          vld_d   = 1'b0;
          state_d = S_REL;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          vld_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_REL;
        end
      end
      S_REL: begin
        ptr_d   = (owner_q == PW'(PORTNUM - 1)) ? '0 : owner_q + PW'(1);
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE) && !bus.i_full;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      nresp_q <= '0;
      vld_q   <= 1'b0;
      ready_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      nresp_q <= nresp_d;
      vld_q   <= vld_d;
      ready_q <= ready_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.o_resp       = resp_q;
  assign bus.o_nresp      = nresp_q;
  assign bus.o_port_ready = ready_q;
  assign bus.o_owner      = owner_q;
  assign bus.o_owner_vld  = vld_q;
  assign bus.o_timeout    = tmo_q;
endmodule

// File: tb/tb_oport_arb.sv
// Bench for oport_arb: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration rules.
module tb_oport_arb;
  localparam int PN = 16;
  localparam int TO = 8;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  oport_arb_if #(.PORTNUM(PN)) bus ();
  oport_arb #(.PORTNUM(PN), .TIMEOUT(TO)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  // Reference model: tracks grant ownership and age in cycles, not RTL states.
  logic [PW-1:0] m_owner = '0;
  int            m_ptr   = 0;
  int            m_age   = 0;
  bit            m_busy  = 1'b0;
  bit            m_rel   = 1'b0;
  bit            m_vld   = 1'b0;
  logic [PN-1:0] e_resp  = '0;
  logic [PN-1:0] e_nresp = '0;
  bit            e_ready = 1'b0;
  bit            e_tmo   = 1'b0;

  always @(posedge clk) begin
    int idx;
    int win;
    e_resp  = '0;
    e_nresp = '0;
    e_tmo   = 1'b0;
    if (rst) begin
      m_ptr = 0; m_owner = '0; m_vld = 0; m_busy = 0; m_rel = 0; m_age = 0; e_ready = 0;
    end else if (m_rel) begin
      m_ptr   = (int'(m_owner) + 1) % PN;
      m_rel   = 0;
      e_ready = !bus.i_full;
    end else if (m_busy) begin
      e_ready = 0;
      if (bus.i_done) begin
        m_busy = 0; m_rel = 1; m_vld = 0;
      end else if (m_age == TO - 1) begin
        m_busy = 0; m_rel = 1; m_vld = 0; e_tmo = 1;
      end else begin
        m_age++;
      end
    end else if (bus.i_req != '0) begin
      e_ready = 0;
      if (bus.i_full) begin
        e_nresp = bus.i_req;
      end else begin
        win = 0;
        // scan priority order backwards so the last hit is the highest-priority one
        for (int k = PN - 1; k >= 0; k--) begin
          idx = (m_ptr + k) % PN;
          if (bus.i_req[idx[3:0]]) win = idx;
        end
        e_resp[win[3:0]] = 1'b1;
        m_owner = win[3:0];
        m_vld = 1; m_busy = 1; m_age = 0;
      end
    end else begin
      e_ready = !bus.i_full;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_grant();
    bus.i_done = 1'b1;
    step();
    bus.i_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.i_req = '0; bus.i_full = 1'b0; bus.i_done = 1'b0;
    step(); step();
    n_total++;
    if ({bus.o_resp, bus.o_nresp, bus.o_port_ready, bus.o_owner, bus.o_owner_vld, bus.o_timeout} !== '0)
      $display("FAIL reset_outputs: got %h want 0",
               {bus.o_resp, bus.o_nresp, bus.o_port_ready, bus.o_owner, bus.o_owner_vld, bus.o_timeout});
    else n_pass++;
    rst = 1'b0;
    step();
    n_total++;
    if (bus.o_port_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", bus.o_port_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    bus.i_req = 16'h0008;
    step();
    bus.i_req = '0;
    n_total++;
    if (bus.o_resp !== 16'h0008 || bus.o_owner !== 4'd3 || bus.o_owner_vld !== 1'b1 || bus.o_port_ready !== 1'b0)
      $display("FAIL single_grant: got resp=%h owner=%0d vld=%b rdy=%b want resp=0008 owner=3 vld=1 rdy=0",
               bus.o_resp, bus.o_owner, bus.o_owner_vld, bus.o_port_ready);
    else n_pass++;
    repeat (5) step();
    bus.i_done = 1'b1;
    step();
    bus.i_done = 1'b0;
    n_total++;
    if (bus.o_owner_vld !== 1'b0 || bus.o_owner !== 4'd3 || bus.o_port_ready !== 1'b0 || bus.o_resp !== '0)
      $display("FAIL single_release: got vld=%b owner=%0d rdy=%b resp=%h want vld=0 owner=3 rdy=0 resp=0",
               bus.o_owner_vld, bus.o_owner, bus.o_port_ready, bus.o_resp);
    else n_pass++;
    step();
    n_total++;
    if (bus.o_port_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", bus.o_port_ready);
    else n_pass++;
    // ports 3 and 4 compete; priority pointer now at 4
    bus.i_req = 16'h0018;
    step();
    bus.i_req = '0;
    n_total++;
    if (bus.o_owner !== 4'd4 || bus.o_resp !== 16'h0010)
      $display("FAIL ptr_after_single: got owner=%0d resp=%h want owner=4 resp=0010", bus.o_owner, bus.o_resp);
    else n_pass++;
    finish_grant();
  endtask

  task automatic test_round_robin();
    int            want;
    int            w;
    logic [PN-1:0] wr;
    for (int i = 0; i < 6; i++) begin
      w = 0;
      while (w < 20 && bus.o_port_ready !== 1'b1) begin
        step();
        w++;
      end
      n_total++;
      if (w >= 20) $display("FAIL rr_wait_ready: got ready=%b want 1 within 20 cycles", bus.o_port_ready);
      else n_pass++;
      bus.i_req = 16'h8001;
      step();
      bus.i_req = '0;
      want = (i % 2 == 0) ? 15 : 0;
      wr = '0;
      wr[want[3:0]] = 1'b1;
      n_total++;
      if (bus.o_resp !== wr || bus.o_owner !== want[3:0] || bus.o_nresp !== '0)
        $display("FAIL rr_grant_%0d: got resp=%h owner=%0d nresp=%h want resp=%h owner=%0d nresp=0",
                 i, bus.o_resp, bus.o_owner, bus.o_nresp, wr, want);
      else n_pass++;
      step(); step();
      finish_grant();
    end
  endtask

  task automatic test_full_reject();
    bus.i_full = 1'b1;
    step();
    bus.i_req = 16'h0030;
    step();
    bus.i_req = '0;
    n_total++;
    if (bus.o_nresp !== 16'h0030 || bus.o_resp !== '0 || bus.o_port_ready !== 1'b0)
      $display("FAIL full_reject: got nresp=%h resp=%h rdy=%b want nresp=0030 resp=0 rdy=0",
               bus.o_nresp, bus.o_resp, bus.o_port_ready);
    else n_pass++;
    step();
    n_total++;
    if (bus.o_nresp !== '0 || bus.o_port_ready !== 1'b0)
      $display("FAIL full_reject_pulse: got nresp=%h rdy=%b want nresp=0 rdy=0", bus.o_nresp, bus.o_port_ready);
    else n_pass++;
    bus.i_full = 1'b0;
    step();
    n_total++;
    if (bus.o_port_ready !== 1'b1) $display("FAIL full_clear_ready: got %b want 1", bus.o_port_ready);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    bus.i_req = 16'h0004;
    step();
    bus.i_req = 16'h0010;
    n_total++;
    if (bus.o_owner !== 4'd2 || bus.o_resp !== 16'h0004)
      $display("FAIL busy_grant: got owner=%0d resp=%h want owner=2 resp=0004", bus.o_owner, bus.o_resp);
    else n_pass++;
    step();
    bus.i_req = '0;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (bus.o_resp !== '0 || bus.o_nresp !== '0 || bus.o_owner !== 4'd2 || bus.o_owner_vld !== 1'b1)
        $display("FAIL busy_ignore_%0d: got resp=%h nresp=%h owner=%0d vld=%b want resp=0 nresp=0 owner=2 vld=1",
                 k, bus.o_resp, bus.o_nresp, bus.o_owner, bus.o_owner_vld);
      else n_pass++;
      step();
    end
    finish_grant();
  endtask

  task automatic test_timeout();
    bus.i_req = 16'h0040;
    step();
    bus.i_req = '0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_total++;
      if (bus.o_timeout !== (k == 8) || (k == 8 && bus.o_owner_vld !== 1'b0))
        $display("FAIL timeout_cycle_%0d: got tmo=%b vld=%b want tmo=%b", k, bus.o_timeout, bus.o_owner_vld, k == 8);
      else n_pass++;
    end
    step();
    n_total++;
    if (bus.o_port_ready !== 1'b1 || bus.o_timeout !== 1'b0)
      $display("FAIL timeout_idle: got rdy=%b tmo=%b want rdy=1 tmo=0", bus.o_port_ready, bus.o_timeout);
    else n_pass++;
    // done arrives exactly in the last allowed busy cycle
    bus.i_req = 16'h0080;
    step();
    bus.i_req = '0;
    repeat (7) step();
    bus.i_done = 1'b1;
    step();
    bus.i_done = 1'b0;
    n_total++;
    if (bus.o_timeout !== 1'b0 || bus.o_owner_vld !== 1'b0 || bus.o_owner !== 4'd7)
      $display("FAIL done_vs_timeout: got tmo=%b vld=%b owner=%0d want tmo=0 vld=0 owner=7",
               bus.o_timeout, bus.o_owner_vld, bus.o_owner);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_busy();
    bus.i_req = 16'h0020;
    step();
    bus.i_req = '0;
    step();
    n_total++;
    if (bus.o_owner !== 4'd5 || bus.o_owner_vld !== 1'b1)
      $display("FAIL rst_busy_owner: got owner=%0d vld=%b want owner=5 vld=1", bus.o_owner, bus.o_owner_vld);
    else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++;
    if ({bus.o_resp, bus.o_nresp, bus.o_port_ready, bus.o_owner, bus.o_owner_vld, bus.o_timeout} !== '0)
      $display("FAIL rst_busy_outputs: got %h want 0",
               {bus.o_resp, bus.o_nresp, bus.o_port_ready, bus.o_owner, bus.o_owner_vld, bus.o_timeout});
    else n_pass++;
    step();
    bus.i_req = 16'h0021;
    step();
    bus.i_req = '0;
    n_total++;
    if (bus.o_owner !== 4'd0 || bus.o_resp !== 16'h0001)
      $display("FAIL rst_busy_ptr: got owner=%0d resp=%h want owner=0 resp=0001", bus.o_owner, bus.o_resp);
    else n_pass++;
    finish_grant();
  endtask

  task automatic test_random();
    logic [40:0] got;
    logic [40:0] want;
    for (int c = 0; c < 400; c++) begin
      bus.i_req  = ($urandom_range(0, 2) == 0) ? PN'($urandom) : '0;
      bus.i_full = ($urandom_range(0, 4) == 0);
      bus.i_done = ($urandom_range(0, 5) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      step();
      got  = {bus.o_resp, bus.o_nresp, bus.o_port_ready, bus.o_owner, bus.o_owner_vld, bus.o_timeout};
      want = {e_resp, e_nresp, e_ready, m_owner, m_vld, e_tmo};
      n_total++;
      if (got !== want) $display("FAIL random_cycle_%0d: got %h want %h", c, got, want);
      else n_pass++;
    end
    bus.i_req = '0; bus.i_full = 1'b0; bus.i_done = 1'b0; rst = 1'b0;
  endtask

  initial begin
    bus.i_req = '0; bus.i_full = 1'b0; bus.i_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_reject();
    test_busy_ignore();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
